// File: rtl/hamming_decoder_pipe.sv
// Purpose : two-stage SECDED (16,11) decoder with saturating error-statistics counters.
// Latency : 2 cycles from accepted codeword to out_valid when downstream does not stall.
// Backpressure: valid/ready; a stalled result holds stage 2, stage 1 fills behind it, then in_ready drops.
//
// Ports:
//   clk, rst                 sole clock; synchronous active-high reset
//   in_valid/in_ready        codeword handshake; codeword_in = {d10..d4,p4,d3..d1,p3,d0,p2,p1,p0}
//   out_valid/out_ready      result handshake; data_out, err_single, err_double, err_pos
//   cnt_clr                  synchronous clear of both counters (wins over an increment)
//   corr_cnt, uncorr_cnt     saturating counts of accepted single / double error results
module hamming_decoder_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      codeword_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [10:0]      data_out,
  output logic             err_single,
  output logic             err_double,
  output logic [3:0]       err_pos,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Stage 1: only the data bits are kept; the parity bits are fully summarised
  // by the syndrome and the overall parity, so nothing else is needed downstream.
  logic        r_s1_vld;
  logic [10:0] r_s1_dat;
  logic [3:0]  r_s1_syn;
  logic        r_s1_q;

  // Stage 2: registered decode result, drives the out_* ports directly.
  logic        r_s2_vld;
  logic [10:0] r_s2_dat;
  logic        r_s2_single;
  logic        r_s2_double;
  logic [3:0]  r_s2_pos;

  logic [CNT_W-1:0] r_corr_cnt;
  logic [CNT_W-1:0] r_uncorr_cnt;

  logic [3:0]  w_syn;
  logic        w_q;
  logic [10:0] w_dat_fix;
  logic        w_single;
  logic        w_double;
  logic [3:0]  w_pos;
  logic        w_s2_load;
  logic        w_out_acc;

  // Syndrome is the XOR of the indices of all set bits; bit 0 has index 0 and
  // therefore only contributes to the overall parity.
  always_comb begin
    w_syn = '0;
    for (int i = 1; i < 16; i++) begin
      if (codeword_in[i]) begin
        w_syn = w_syn ^ 4'(i);
      end
    end
  end

  assign w_q = ^codeword_in;

  // Single error (q=1): flip the bit at the syndrome position. Only data
  // positions matter for data_out; a flip of a parity position (0,1,2,4,8)
  // leaves the data unchanged.
  always_comb begin
    w_dat_fix = r_s1_dat;
    if (r_s1_q) begin
      case (r_s1_syn)
        4'd3:    w_dat_fix[0]  = ~r_s1_dat[0];
        4'd5:    w_dat_fix[1]  = ~r_s1_dat[1];
        4'd6:    w_dat_fix[2]  = ~r_s1_dat[2];
        4'd7:    w_dat_fix[3]  = ~r_s1_dat[3];
        4'd9:    w_dat_fix[4]  = ~r_s1_dat[4];
        4'd10:   w_dat_fix[5]  = ~r_s1_dat[5];
        4'd11:   w_dat_fix[6]  = ~r_s1_dat[6];
        4'd12:   w_dat_fix[7]  = ~r_s1_dat[7];
        4'd13:   w_dat_fix[8]  = ~r_s1_dat[8];
        4'd14:   w_dat_fix[9]  = ~r_s1_dat[9];
        4'd15:   w_dat_fix[10] = ~r_s1_dat[10];
        default: w_dat_fix     = r_s1_dat;
      endcase
    end
  end

  assign w_single = r_s1_q;
  assign w_double = !r_s1_q && (r_s1_syn != 4'd0);
  assign w_pos    = r_s1_q ? r_s1_syn : 4'd0;

  // Stage 2 loads whenever it is empty or its result is being taken; stage 1
  // moves forward exactly when stage 2 loads.
  assign w_s2_load = !r_s2_vld || out_ready;
  assign in_ready  = !r_s1_vld || w_s2_load;
  assign w_out_acc = r_s2_vld && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld     <= 1'b0;
      r_s1_dat     <= '0;
      r_s1_syn     <= '0;
      r_s1_q       <= 1'b0;
      r_s2_vld     <= 1'b0;
      r_s2_dat     <= '0;
      r_s2_single  <= 1'b0;
      r_s2_double  <= 1'b0;
      r_s2_pos     <= '0;
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else begin
      if (in_ready) begin
        r_s1_vld <= in_valid;
        if (in_valid) begin
          r_s1_dat <= {codeword_in[15:9], codeword_in[7:5], codeword_in[3]};
          r_s1_syn <= w_syn;
          r_s1_q   <= w_q;
        end
      end

      if (w_s2_load) begin
        r_s2_vld <= r_s1_vld;
        if (r_s1_vld) begin
          r_s2_dat    <= w_dat_fix;
          r_s2_single <= w_single;
          r_s2_double <= w_double;
          r_s2_pos    <= w_pos;
        end
      end

      // Clear has priority over a same-cycle increment; counters stick at all-ones.
      if (cnt_clr) begin
        r_corr_cnt   <= '0;
        r_uncorr_cnt <= '0;
      end else if (w_out_acc) begin
        if (r_s2_single && (r_corr_cnt != '1)) begin
          r_corr_cnt <= r_corr_cnt + CNT_ONE;
        end
        if (r_s2_double && (r_uncorr_cnt != '1)) begin
          r_uncorr_cnt <= r_uncorr_cnt + CNT_ONE;
        end
      end
    end
  end

  assign out_valid  = r_s2_vld;
  assign data_out   = r_s2_dat;
  assign err_single = r_s2_single;
  assign err_double = r_s2_double;
  assign err_pos    = r_s2_pos;
  assign corr_cnt   = r_corr_cnt;
  assign uncorr_cnt = r_uncorr_cnt;

endmodule

// File: tb/tb_hamming_decoder_pipe.sv
// Purpose : self-checking bench for hamming_decoder_pipe (default and 2-bit counter instances).
// Latency : checks 2-cycle accept-to-valid, ordering and output hold under stalls.
// Backpressure: random and scripted out_ready stalls; sender holds words until in_ready.
module tb_hamming_decoder_pipe;

  typedef struct packed {
    logic [10:0] dat;
    logic        single;
    logic        dbl;
    logic [3:0]  pos;
  } exp_t;

  typedef struct packed {
    logic [15:0] cw;
    exp_t        e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] codeword_in;
  logic        out_ready;
  logic        cnt_clr;

  logic        in_ready, out_valid, err_single, err_double;
  logic [10:0] data_out;
  logic [3:0]  err_pos;
  logic [15:0] corr_cnt, uncorr_cnt;

  logic        s_in_ready, s_out_valid, s_err_single, s_err_double;
  logic [10:0] s_data_out;
  logic [3:0]  s_err_pos;
  logic [1:0]  s_corr_cnt, s_uncorr_cnt;

  hamming_decoder_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .codeword_in(codeword_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .err_single(err_single), .err_double(err_double),
    .err_pos(err_pos), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  hamming_decoder_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .codeword_in(codeword_in), .out_valid(s_out_valid), .out_ready(out_ready),
    .data_out(s_data_out), .err_single(s_err_single), .err_double(s_err_double),
    .err_pos(s_err_pos), .cnt_clr(cnt_clr), .corr_cnt(s_corr_cnt), .uncorr_cnt(s_uncorr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t cur_exp;
  exp_t exp_q[$];
  int   m_corr = 0;
  int   m_uncorr = 0;
  logic hold = 1'b0;
  logic [17:0] held;
  exp_t mon_e;
  logic rnd_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // Reference encoder: data fills the non-power-of-two positions in order,
  // each parity bit p covers the positions whose index has bit p set,
  // bit 0 makes the whole word even.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] cw;
    logic        par;
    int          k;
    cw = '0;
    k  = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos] = d[k];
        k++;
      end
    end
    for (int p = 1; p < 16; p = p * 2) begin
      par = 1'b0;
      for (int pos = 1; pos < 16; pos++) begin
        if ((pos & p) != 0) par = par ^ cw[pos];
      end
      cw[p] = par;
    end
    cw[0] = ^cw[15:1];
    return cw;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] cw);
    logic [10:0] d;
    int          k;
    d = '0;
    k = 0;
    for (int pos = 1; pos < 16; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = cw[pos];
        k++;
      end
    end
    return d;
  endfunction

  // Scoreboard: handshakes are judged at negedge, where the inputs and the
  // combinational in_ready already hold the values the next posedge will see.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_corr   = 0;
      m_uncorr = 0;
      hold     = 1'b0;
    end else begin
      chk("corr_cnt", corr_cnt, m_corr);
      chk("uncorr_cnt", uncorr_cnt, m_uncorr);
      chk("sat_corr_cnt", s_corr_cnt, sat3(m_corr));
      chk("sat_uncorr_cnt", s_uncorr_cnt, sat3(m_uncorr));
      if (hold) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_outputs", {data_out, err_single, err_double, err_pos}, held);
      end
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
      mon_e = '0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("output_without_input", out_valid, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("data_out", data_out, mon_e.dat);
          chk("err_single", err_single, mon_e.single);
          chk("err_double", err_double, mon_e.dbl);
          chk("err_pos", err_pos, mon_e.pos);
          chk("sat_valid", s_out_valid, 1'b1);
          chk("sat_result", {s_data_out, s_err_single, s_err_double, s_err_pos}, mon_e);
        end
      end
      if (cnt_clr) begin
        m_corr   = 0;
        m_uncorr = 0;
      end else if (out_valid && out_ready) begin
        if (mon_e.single) m_corr++;
        if (mon_e.dbl) m_uncorr++;
      end
      hold = out_valid && !out_ready;
      held = {data_out, err_single, err_double, err_pos};
    end
  end

  always @(posedge clk) begin
    if (rnd_on) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 29) == 0);
    end
  end

  task automatic send(input logic [15:0] cw, input exp_t e);
    logic acc;
    acc         = 1'b0;
    in_valid    = 1'b1;
    codeword_in = cw;
    cur_exp     = e;
    for (int k = 0; k < 500 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", acc, 1'b1);
  endtask

  task automatic drain();
    for (int k = 0; k < 2000 && exp_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Random word with 0, 1 or 2 distinct flipped bits and its expected result.
  task automatic send_random(input int nflip);
    logic [10:0] d;
    logic [15:0] cw;
    int          b1, b2;
    exp_t        e;
    d  = 11'($urandom);
    cw = encode(d);
    b1 = $urandom_range(0, 15);
    b2 = (b1 + $urandom_range(1, 15)) % 16;
    e  = '{dat: d, single: 1'b0, dbl: 1'b0, pos: 4'd0};
    if (nflip == 1) begin
      cw[b1]   = ~cw[b1];
      e.single = 1'b1;
      e.pos    = 4'(b1);
    end else if (nflip == 2) begin
      cw[b1] = ~cw[b1];
      cw[b2] = ~cw[b2];
      e.dbl  = 1'b1;
      e.dat  = extract(cw);
    end
    send(cw, e);
  endtask

  vec_t vecs[9];
  int   lat;
  logic saw_low;

  initial begin
    vecs[0] = '{cw: 16'hB44B, e: '{dat: 11'h5A5, single: 1'b0, dbl: 1'b0, pos: 4'd0}};
    vecs[1] = '{cw: 16'hB40B, e: '{dat: 11'h5A5, single: 1'b1, dbl: 1'b0, pos: 4'd6}};
    vecs[2] = '{cw: 16'hB44A, e: '{dat: 11'h5A5, single: 1'b1, dbl: 1'b0, pos: 4'd0}};
    vecs[3] = '{cw: 16'hB60B, e: '{dat: 11'h5B1, single: 1'b0, dbl: 1'b1, pos: 4'd0}};
    vecs[4] = '{cw: 16'h0000, e: '{dat: 11'h000, single: 1'b0, dbl: 1'b0, pos: 4'd0}};
    vecs[5] = '{cw: 16'hFFFF, e: '{dat: 11'h7FF, single: 1'b0, dbl: 1'b0, pos: 4'd0}};
    vecs[6] = '{cw: 16'h7FFF, e: '{dat: 11'h7FF, single: 1'b1, dbl: 1'b0, pos: 4'd15}};
    vecs[7] = '{cw: 16'h0001, e: '{dat: 11'h000, single: 1'b1, dbl: 1'b0, pos: 4'd0}};
    vecs[8] = '{cw: 16'hB448, e: '{dat: 11'h5A5, single: 1'b0, dbl: 1'b1, pos: 4'd0}};

    rst = 1'b1; in_valid = 1'b0; codeword_in = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    cur_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_data_out", data_out, 11'h000);
    chk("rst_err_single", err_single, 1'b0);
    chk("rst_err_double", err_double, 1'b0);
    chk("rst_err_pos", err_pos, 4'd0);
    chk("rst_corr_cnt", corr_cnt, 16'd0);
    chk("rst_uncorr_cnt", uncorr_cnt, 16'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;

    // Latency: one word, count posedges from acceptance until out_valid.
    @(posedge clk); #1;
    in_valid = 1'b1; codeword_in = vecs[0].cw; cur_exp = vecs[0].e;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 2);
    drain();

    foreach (vecs[i]) begin
      send(vecs[i].cw, vecs[i].e);
      drain();
    end

    // Eight back-to-back words with a 3-cycle downstream stall in the middle.
    saw_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(encode(11'(i * 151 + 7)), '{dat: 11'(i * 151 + 7), single: 1'b0, dbl: 1'b0, pos: 4'd0});
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (!in_ready) saw_low = 1'b1;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    chk("in_ready_drops_on_stall", saw_low, 1'b1);
    drain();

    // Saturation of the 2-bit instance after five corrected words.
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    repeat (5) send_random(1);
    drain();
    chk("corr_after_5", corr_cnt, 16'd5);
    chk("sat_corr_after_5", s_corr_cnt, 2'd3);

    // Clear in the same cycle as an accepted single-error result: clear wins.
    out_ready = 1'b0;
    send_random(1);
    repeat (2) @(posedge clk);
    #1;
    chk("stalled_valid", out_valid, 1'b1);
    cnt_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_wins_corr", corr_cnt, 16'd0);
    chk("clr_wins_sat_corr", s_corr_cnt, 2'd0);

    // Reset with two words in flight: nothing may come out afterwards.
    out_ready = 1'b0;
    send_random(0);
    send_random(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_output", out_valid, 1'b0);

    // Random traffic with random stalls, clears and error injection.
    rnd_on = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send_random($urandom_range(0, 2));
    end
    rnd_on = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    cnt_clr = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
